filter_window_ctrl: RTL and testbench
=====================================

Name: filter_window_ctrl

Overview:
- Frame-level sequencer for the ROM → line_buffer → matrix_5x5 filter datapath.
- Owns the ROM read address for the filter path and the line-buffer FIFO reset, and sequences that reset.
- Prefills KSIZE-1 image lines, then produces one filtered output row per request, issuing aligned write, read and matrix-valid strobes.
- Sits between the display timing/pixel-select logic and the window datapath; replaces free-running coordinate decode with an explicit handshake.

Parameters:
- PIC_WIDTH, 250, pixels per image line.
- PIC_HEIGHT, 250, lines per image.
- KSIZE, 5, window size; output rows OUT_ROWS = PIC_HEIGHT-KSIZE+1.
- ADDR_W, 16, ROM address width; PIC_WIDTH*PIC_HEIGHT must be <= 2^ADDR_W.
- FLUSH_CYC, 4, cycles fifo_rst_n is held low.
- ROW_GAP, 8, idle cycles between auto-started rows (AUTO_ROW_EN only).

Ports:
- lcd_pclk  in  1  clock
- rst  in  1  synchronous reset, active-high
- frame_start  in  1  one-cycle pulse: (re)start a frame
- fifo_rst_busy  in  1  line-buffer FIFOs still resetting
- row_req  in  1  one-cycle pulse: produce next output row
- rom_addr  out  ADDR_W  ROM read address
- rom_rd_en  out  1  address valid this cycle
- fifo_rst_n  out  1  line-buffer FIFO reset, active-low
- buf_wr_en  out  1  line-buffer valid_in
- buf_rd_en  out  1  line-buffer rd_en_all
- matrix_valid  out  1  matrix valid_in
- row_ready  out  1  high in READY
- row_done  out  1  one-cycle pulse at row end
- frame_done  out  1  one-cycle pulse after last row
- row_cnt  out  11  output rows completed this frame
- err_overrun  out  1  sticky: row_req arrived outside READY

Behaviour:
- Reset values: all outputs 0 except fifo_rst_n=1; state IDLE; internal pixel/line counters 0; delay pipeline cleared.
- ROM latency is 1 cycle. buf_wr_en, buf_rd_en and matrix_valid are registered copies of their issue-cycle enables, delayed by 1, so they align with rom data.
- FSM states: IDLE, FLUSH, WAIT_BUSY, PREFILL, READY, ROW, DONE.
- IDLE: waits for frame_start.
- FLUSH:
  - Entered on the cycle after frame_start is sampled, from ANY state.
  - Holds fifo_rst_n=0 for exactly FLUSH_CYC cycles.
  - Clears address, row_cnt, err_overrun and delayed strobes.
- WAIT_BUSY: fifo_rst_n=1; leaves on the first cycle fifo_rst_busy=0.
- PREFILL:
  - Issues addresses 0 .. (KSIZE-1)*PIC_WIDTH-1, one per cycle, rom_rd_en=1.
  - Write strobe only (buf_wr_en); no reads, no matrix_valid.
  - Then goes to READY.
- READY: row_ready=1; on row_req goes to ROW next cycle.
- ROW:
  - PIC_WIDTH issue cycles. Each issue cycle sets rom_rd_en=1 and schedules write+read+matrix strobes; rom_addr continues sequentially.
  - Row r writes image line KSIZE-1+r.
  - After the last issue cycle, one tail cycle flushes the delayed strobes.
  - row_done pulses in the tail cycle and row_cnt increments there.
  - Next state is DONE if row_cnt reaches OUT_ROWS, else READY.
- DONE: frame_done=1 for one cycle, then IDLE. rom_addr then equals PIC_WIDTH*PIC_HEIGHT (wrap to 0 only on next frame_start).
- Total lines written per frame = PIC_HEIGHT exactly; no read past image end.
- row_req outside READY: ignored, sets err_overrun (cleared only by rst or frame_start).
- frame_start during ROW/PREFILL: abort. All enables drop the next cycle, including pending delayed strobes. No row_done or frame_done for the aborted frame.
- frame_start coincident with row_req: frame_start wins; no err_overrun.
- fifo_rst_busy reasserting outside WAIT_BUSY: ignored.
- rst mid-frame: full return to reset values the next cycle.

Optional Feature:
- Macro AUTO_ROW_EN.
- Defined: READY self-advances to ROW after ROW_GAP idle cycles; row_req is ignored and err_overrun stays 0.
- Undefined: rows start only on row_req; ROW_GAP is unused.

Test Plan:
- PIC_WIDTH=8, PIC_HEIGHT=6, KSIZE=3, fifo_rst_busy low: frame_start → fifo_rst_n low 4 cycles; PREFILL addrs 0..15; buf_wr_en 16 cycles lagging by 1; row_ready=1.
- Same config, row_req ×4: each row issues 8 addrs (16..23, 24..31, 32..39, 40..47); buf_rd_en=matrix_valid=buf_wr_en for 8 cycles; row_cnt 1..4; frame_done after row 4; rom_addr=48.
- fifo_rst_busy held high 10 cycles after FLUSH: no rom_rd_en until the cycle after it falls; then PREFILL starts at addr 0.
- row_req during PREFILL: ignored, err_overrun=1; cleared by next frame_start.
- frame_start at issue cycle 3 of row 2: strobes low next cycle, no row_done, FLUSH restarts, addr 0 on new PREFILL.
- AUTO_ROW_EN, ROW_GAP=8: rows start 8 cycles after each READY entry with no row_req; 4 rows and frame_done as above.

Source files
------------

// File: rtl/filter_window_ctrl.sv
// filter_window_ctrl: frame sequencer for the ROM -> line_buffer -> matrix filter path.
// Define AUTO_ROW_EN to have rows start automatically ROW_GAP cycles after READY entry.
module filter_window_ctrl #(
    parameter int PIC_WIDTH  = 250,
    parameter int PIC_HEIGHT = 250,
    parameter int KSIZE      = 5,
    parameter int ADDR_W     = 16,
    parameter int FLUSH_CYC  = 4,
    parameter int ROW_GAP    = 8
) (
    input  logic              i_lcd_pclk,
    input  logic              i_rst,
    input  logic              i_frame_start,
    input  logic              i_fifo_rst_busy,
    input  logic              i_row_req,
    output logic [ADDR_W-1:0] o_rom_addr,
    output logic              o_rom_rd_en,
    output logic              o_fifo_rst_n,
    output logic              o_buf_wr_en,
    output logic              o_buf_rd_en,
    output logic              o_matrix_valid,
    output logic              o_row_ready,
    output logic              o_row_done,
    output logic              o_frame_done,
    output logic [10:0]       o_row_cnt,
    output logic              o_err_overrun
);
    localparam int OUT_ROWS = PIC_HEIGHT - KSIZE + 1;
    localparam int CNT_A    = PIC_WIDTH > FLUSH_CYC ? PIC_WIDTH : FLUSH_CYC;
    localparam int CNT_MAX  = CNT_A > ROW_GAP ? CNT_A : ROW_GAP;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0]  W_LAST   = CNT_W'(PIC_WIDTH - 1);
    localparam logic [CNT_W-1:0]  F_LAST   = CNT_W'(FLUSH_CYC - 1);
    localparam logic [ADDR_W-1:0] PRE_LAST = ADDR_W'((KSIZE - 1) * PIC_WIDTH - 1);
    localparam logic [10:0]       ROWS_END = 11'(OUT_ROWS);

    typedef enum logic [2:0] {IDLE, FLUSH, WAIT_BUSY, PREFILL, READY, ROW, DONE} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]  r_rom_addr;
    logic [10:0]        r_row_cnt;
    logic               r_rom_rd_en, r_fifo_rst_n, r_buf_wr_en, r_buf_rd_en, r_matrix_valid;
    logic               r_row_ready, r_row_done, r_frame_done, r_err_overrun;
    logic               w_go, w_overrun;

`ifdef AUTO_ROW_EN
    localparam logic [CNT_W-1:0] G_LAST = CNT_W'(ROW_GAP - 1);
    assign w_go      = r_cnt == G_LAST;
    assign w_overrun = 1'b0;
`else
    assign w_go      = i_row_req;
    assign w_overrun = i_row_req && r_state != READY;
`endif

    always_ff @(posedge i_lcd_pclk) begin
        if (i_rst || i_frame_start) begin
            r_state        <= i_rst ? IDLE : FLUSH;
            r_fifo_rst_n   <= i_rst;
            r_cnt          <= '0;
            r_rom_addr     <= '0;
            r_row_cnt      <= '0;
            r_rom_rd_en    <= 1'b0;
            r_buf_wr_en    <= 1'b0;
            r_buf_rd_en    <= 1'b0;
            r_matrix_valid <= 1'b0;
            r_row_ready    <= 1'b0;
            r_row_done     <= 1'b0;
            r_frame_done   <= 1'b0;
            r_err_overrun  <= 1'b0;
        end else begin
            // Strobes trail the issue cycle by one to line up with ROM data.
            r_buf_wr_en    <= r_rom_rd_en;
            r_buf_rd_en    <= r_rom_rd_en && r_state == ROW;
            r_matrix_valid <= r_rom_rd_en && r_state == ROW;
            r_row_done     <= 1'b0;
            r_frame_done   <= 1'b0;
            if (w_overrun) r_err_overrun <= 1'b1;
            if (r_rom_rd_en) r_rom_addr <= r_rom_addr + 1'b1;
            case (r_state)
                FLUSH: begin
                    if (r_cnt == F_LAST) begin
                        r_state      <= WAIT_BUSY;
                        r_fifo_rst_n <= 1'b1;
                    end else r_cnt <= r_cnt + 1'b1;
                end
                WAIT_BUSY: begin
                    if (!i_fifo_rst_busy) begin
                        r_state     <= PREFILL;
                        r_rom_rd_en <= 1'b1;
                    end
                end
                PREFILL: begin
                    if (r_rom_addr == PRE_LAST) begin
                        r_state     <= READY;
                        r_rom_rd_en <= 1'b0;
                        r_row_ready <= 1'b1;
                        r_cnt       <= '0;
                    end
                end
                READY: begin
                    if (w_go) begin
                        r_state     <= ROW;
                        r_row_ready <= 1'b0;
                        r_rom_rd_en <= 1'b1;
                        r_cnt       <= '0;
                    end else r_cnt <= r_cnt + 1'b1;
                end
                ROW: begin
                    if (r_rom_rd_en) begin
                        if (r_cnt == W_LAST) begin
                            r_rom_rd_en <= 1'b0;
                            r_row_done  <= 1'b1;
                            r_row_cnt   <= r_row_cnt + 1'b1;
                        end else r_cnt <= r_cnt + 1'b1;
                    end else begin
                        // Tail cycle: row_cnt already reflects the finished row.
                        r_state      <= r_row_cnt == ROWS_END ? DONE : READY;
                        r_row_ready  <= r_row_cnt != ROWS_END;
                        r_frame_done <= r_row_cnt == ROWS_END;
                        r_cnt        <= '0;
                    end
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_rom_addr     = r_rom_addr;
    assign o_rom_rd_en    = r_rom_rd_en;
    assign o_fifo_rst_n   = r_fifo_rst_n;
    assign o_buf_wr_en    = r_buf_wr_en;
    assign o_buf_rd_en    = r_buf_rd_en;
    assign o_matrix_valid = r_matrix_valid;
    assign o_row_ready    = r_row_ready;
    assign o_row_done     = r_row_done;
    assign o_frame_done   = r_frame_done;
    assign o_row_cnt      = r_row_cnt;
    assign o_err_overrun  = r_err_overrun;
endmodule

// File: tb/tb_filter_window_ctrl.sv
// tb_filter_window_ctrl: scoreboard bench for filter_window_ctrl on an 8x6 image with a 3x3 window.
module tb_filter_window_ctrl;
    localparam int W = 8, H = 6, K = 3, AW = 16, FC = 4, GAP = 8, OUT = H - K + 1;
`ifdef AUTO_ROW_EN
    localparam logic [31:0] EXP_OVR = 0;
`else
    localparam logic [31:0] EXP_OVR = 1;
`endif

    logic clk = 1'b0, rst = 1'b1, frame_start = 1'b0, busy = 1'b0, row_req = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [10:0] row_cnt;
    logic rom_rd_en, fifo_rst_n, buf_wr_en, buf_rd_en, matrix_valid;
    logic row_ready, row_done, frame_done, err_overrun;
    int checks = 0, errors = 0, wr_cnt = 0, rd_cnt = 0;
    int q_addr[$], q_row[$], q_frame[$];
    logic prev_rd = 1'b0, prev_fs = 1'b0, prev_rst = 1'b1;

    always #5 clk = ~clk;

    filter_window_ctrl #(.PIC_WIDTH(W), .PIC_HEIGHT(H), .KSIZE(K), .ADDR_W(AW),
                         .FLUSH_CYC(FC), .ROW_GAP(GAP)) dut (
        .i_lcd_pclk(clk), .i_rst(rst), .i_frame_start(frame_start),
        .i_fifo_rst_busy(busy), .i_row_req(row_req),
        .o_rom_addr(rom_addr), .o_rom_rd_en(rom_rd_en), .o_fifo_rst_n(fifo_rst_n),
        .o_buf_wr_en(buf_wr_en), .o_buf_rd_en(buf_rd_en), .o_matrix_valid(matrix_valid),
        .o_row_ready(row_ready), .o_row_done(row_done), .o_frame_done(frame_done),
        .o_row_cnt(row_cnt), .o_err_overrun(err_overrun));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops expectations whenever the DUT presents an address or a pulse.
    always @(negedge clk) begin
        chk("buf_wr_align", 32'(buf_wr_en), 32'(prev_rd && !prev_fs && !prev_rst));
        chk("matrix_eq_rd", 32'(matrix_valid), 32'(buf_rd_en));
        if (buf_rd_en) chk("rd_implies_wr", 32'(buf_wr_en), 1);
        wr_cnt += int'(buf_wr_en);
        rd_cnt += int'(buf_rd_en);
        if (rom_rd_en) begin
            if (q_addr.size() == 0) chk("addr_unexpected", 32'(rom_rd_en), 0);
            else chk("rom_addr", 32'(rom_addr), q_addr.pop_front());
        end
        if (row_done) begin
            if (q_row.size() == 0) chk("row_done_unexpected", 32'(row_done), 0);
            else chk("row_cnt_at_done", 32'(row_cnt), q_row.pop_front());
        end
        if (frame_done) begin
            if (q_frame.size() == 0) chk("frame_done_unexpected", 32'(frame_done), 0);
            else chk("frame_end_addr", 32'(rom_addr), q_frame.pop_front());
        end
        prev_rd  = rom_rd_en;
        prev_fs  = frame_start;
        prev_rst = rst;
    end

    function automatic logic hit(input int sel);
        case (sel)
            0: return row_ready;
            1: return row_done;
            2: return rom_rd_en;
            3: return row_ready || frame_done;
            default: return fifo_rst_n;
        endcase
    endfunction

    task automatic wait_for(input int sel, input string name);
        int n = 0;
        while (!hit(sel) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(hit(sel)), 1);
        #1;
    endtask

    task automatic start_frame(input logic with_req);
        @(posedge clk); #1 frame_start = 1'b1; row_req = with_req;
        @(posedge clk); #1 frame_start = 1'b0; row_req = 1'b0;
        q_addr.delete(); q_row.delete(); q_frame.delete();
        wr_cnt = 0; rd_cnt = 0;
        for (int a = 0; a < (K - 1) * W; a++) q_addr.push_back(a);
    endtask

    task automatic row_begin(input int r);
        for (int i = 0; i < W; i++) q_addr.push_back((K - 1 + r) * W + i);
        q_row.push_back(r + 1);
        if (r == OUT - 1) q_frame.push_back(W * H);
`ifdef AUTO_ROW_EN
        begin
            int n = 0;
            while (row_ready && n < 50) begin
                n++;
                @(negedge clk);
            end
            chk("auto_gap", n, GAP);
        end
`else
        @(posedge clk); #1 row_req = 1'b1;
        @(posedge clk); #1 row_req = 1'b0;
`endif
        wait_for(2, "row_start");
    endtask

    task automatic full_row(input int r);
        row_begin(r);
        wait_for(1, "row_done_seen");
        wait_for(3, "row_end_seen");
    endtask

    initial begin
        int n;
        logic bad;
        @(negedge clk);
        chk("rst_addr", 32'(rom_addr), 0);
        chk("rst_rd_en", 32'(rom_rd_en), 0);
        chk("rst_fifo_rst_n", 32'(fifo_rst_n), 1);
        chk("rst_row_ready", 32'(row_ready), 0);
        chk("rst_row_cnt", 32'(row_cnt), 0);
        chk("rst_err", 32'(err_overrun), 0);
        @(posedge clk); #1 rst = 1'b0;

        // Full frame, with busy glitching mid-row (must be ignored).
        start_frame(1'b0);
        @(negedge clk);
        n = 0;
        while (!fifo_rst_n && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("flush_len", n, FC);
        wait_for(0, "prefill_ready");
        chk("ready_addr", 32'(rom_addr), (K - 1) * W);
        chk("prefill_wr", wr_cnt, (K - 1) * W);
        chk("prefill_rd", rd_cnt, 0);
        for (int r = 0; r < OUT; r++) begin
            if (r == 1) busy = 1'b1;
            full_row(r);
            busy = 1'b0;
        end
        chk("frame_row_cnt", 32'(row_cnt), OUT);
        chk("frame_row_ready", 32'(row_ready), 0);
        chk("frame_wr_total", wr_cnt, W * H);
        chk("frame_rd_total", rd_cnt, OUT * W);
        chk("frame_addr_left", q_addr.size(), 0);
        chk("frame_done_left", q_frame.size(), 0);
        repeat (3) @(negedge clk);
        chk("idle_addr_hold", 32'(rom_addr), W * H);

        // fifo_rst_busy held high after the flush.
        busy = 1'b1;
        start_frame(1'b0);
        wait_for(4, "flush_end");
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            bad |= rom_rd_en;
        end
        chk("busy_hold", 32'(bad), 0);
        @(posedge clk); #1 busy = 1'b0;
        @(negedge clk);
        chk("busy_fall_cycle", 32'(rom_rd_en), 0);
        @(negedge clk);
        chk("busy_fall_next", 32'(rom_rd_en), 1);
        chk("busy_prefill_addr0", 32'(rom_addr), 0);
        wait_for(0, "busy_ready");

        // row_req during PREFILL, then frame_start together with row_req.
        start_frame(1'b0);
        wait_for(2, "ovr_prefill");
        @(posedge clk); #1 row_req = 1'b1;
        @(posedge clk); #1 row_req = 1'b0;
        chk("ovr_set", 32'(err_overrun), EXP_OVR);
        wait_for(0, "ovr_ready");
        chk("ovr_sticky", 32'(err_overrun), EXP_OVR);
        chk("ovr_rd_idle", 32'(rom_rd_en), 0);
        start_frame(1'b1);
        chk("coincide_err", 32'(err_overrun), 0);
        chk("coincide_flush", 32'(fifo_rst_n), 0);

        // Abort at issue cycle 3 of row 2.
        wait_for(0, "abort_ready");
        full_row(0);
        full_row(1);
        row_begin(2);
        @(posedge clk); #1;
        start_frame(1'b0);
        chk("abort_rd_en", 32'(rom_rd_en), 0);
        chk("abort_buf_wr", 32'(buf_wr_en), 0);
        chk("abort_buf_rd", 32'(buf_rd_en), 0);
        chk("abort_row_done", 32'(row_done), 0);
        chk("abort_fifo_rst_n", 32'(fifo_rst_n), 0);
        chk("abort_row_cnt", 32'(row_cnt), 0);
        wait_for(0, "abort_reprefill");
        chk("abort_prefill_wr", wr_cnt, (K - 1) * W);

        // Reset in the middle of a row.
        row_begin(0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("mid_rst_addr", 32'(rom_addr), 0);
        chk("mid_rst_rd_en", 32'(rom_rd_en), 0);
        chk("mid_rst_fifo", 32'(fifo_rst_n), 1);
        chk("mid_rst_buf_wr", 32'(buf_wr_en), 0);
        repeat (4) @(negedge clk);
        chk("mid_rst_idle", 32'(rom_rd_en), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
